apb_master_ctrl: RTL and testbench



---
 rtl/apbm_pkg.sv | 41 ++++
 rtl/apbm_watchdog.sv | 38 +++
 rtl/apb_master_ctrl.sv | 163 ++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apbm_pkg.sv
// apbm_pkg: shared definitions for the APB requester (apb_master_ctrl).
//   - apbm_state_e : FSM state encoding (IDLE, FETCH, LOAD, SETUP, ACCESS, RESP)
//   - DEF_WIDTH / DEF_ADDRBITS : default APB data and address widths
//   - wr_bit/addr_msb/addr_lsb/data_msb/data_lsb : field offsets inside a
//     request word laid out as {wr, addr, wdata}
package apbm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      SETUP  = 3'd3,
      ACCESS = 3'd4,
      RESP   = 3'd5
   } apbm_state_e;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_ADDRBITS = 16;

   // Request word: write flag on top, address in the middle, data at the bottom.
   function automatic int wr_bit(input int width, input int addrbits);
      return width + addrbits;
   endfunction

   function automatic int addr_msb(input int width, input int addrbits);
      return width + addrbits - 1;
   endfunction

   function automatic int addr_lsb(input int width);
      return width;
   endfunction

   function automatic int data_msb(input int width);
      return width - 1;
   endfunction

   function automatic int data_lsb();
      return 0;
   endfunction

endpackage

// File: rtl/apbm_watchdog.sv
// apbm_watchdog: ACCESS-phase wait-state counter for apb_master_ctrl.
// Only instantiated when APBM_TIMEOUT_EN is defined.
// Ports:
//   apb_clk  in  clock
//   reset    in  async active-low reset
//   active   in  requester is in its ACCESS state
//   pready   in  APB ready from the completer
//   expired  out the current ACCESS cycle must abort (count==TIMEOUT, no pready)
module apbm_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic apb_clk,
   input  logic reset,
   input  logic active,
   input  logic pready,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count;

   // Held at zero outside ACCESS, so each transfer starts counting from zero.
   // The counter stops at LIMIT; the abort moves the FSM out of ACCESS anyway.
   always_ff @(posedge apb_clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (!active) begin
         count <= '0;
      end else if (!pready && (count != LIMIT)) begin
         count <= count + 8'd1;
      end
   end

   // pready in the limit cycle wins: the transfer completes normally.
   assign expired = active && !pready && (count == LIMIT);

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB requester that drains a request FIFO, replays each
// entry as one APB SETUP/ACCESS transfer and pushes read data into a
// response FIFO. Writes produce no response.
// Optional feature macro: APBM_TIMEOUT_EN (ACCESS-phase timeout with a
// sticky timeout_err flag; rsp_data = all ones for an aborted read).
// Ports:
//   apb_clk, reset         clock, async active-low reset
//   req_empty/req_data     request FIFO status and head {wr, addr, wdata}
//   req_ren                request FIFO pop strobe
//   rsp_full               response FIFO full
//   rsp_wen/rsp_data       response FIFO push strobe and read data
//   psel/penable/pwrite    APB control
//   paddr/pwdata/prdata    APB address and data
//   pready                 APB ready
//   busy                   FSM not in IDLE
//   timeout_err            sticky abort flag
//
// Handshakes: the request FIFO is popped by a one-cycle req_ren pulse and its
// head is valid in the following cycle; an APB transfer completes in the
// ACCESS cycle where psel && penable && pready; a response is accepted in the
// cycle where rsp_wen is high, which only happens while rsp_full is low.
module apb_master_ctrl
   import apbm_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ADDRBITS = DEF_ADDRBITS,
   parameter int TIMEOUT  = 255
) (
   input  logic                      apb_clk,
   input  logic                      reset,
   input  logic                      req_empty,
   input  logic [WIDTH+ADDRBITS:0]   req_data,
   output logic                      req_ren,
   input  logic                      rsp_full,
   output logic                      rsp_wen,
   output logic [WIDTH-1:0]          rsp_data,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDRBITS-1:0]       paddr,
   output logic [WIDTH-1:0]          pwdata,
   input  logic [WIDTH-1:0]          prdata,
   input  logic                      pready,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int WR_BIT = wr_bit(WIDTH, ADDRBITS);
   localparam int A_MSB  = addr_msb(WIDTH, ADDRBITS);
   localparam int A_LSB  = addr_lsb(WIDTH);
   localparam int D_MSB  = data_msb(WIDTH);
   localparam int D_LSB  = data_lsb();

   apbm_state_e state_q, state_d;

   logic                cmd_wr;
   logic [ADDRBITS-1:0] cmd_addr;
   logic [WIDTH-1:0]    cmd_wdata;
   logic                expired;

`ifdef APBM_TIMEOUT_EN
   apbm_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .apb_clk (apb_clk),
      .reset   (reset),
      .active  (state_q == ACCESS),
      .pready  (pready),
      .expired (expired)
   );

   always_ff @(posedge apb_clk or negedge reset) begin
      if (!reset) begin
         timeout_err <= 1'b0;
      end else if (expired) begin
         timeout_err <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign expired        = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   always_ff @(posedge apb_clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus strobes. All outputs decode state_q only (rsp_wen also
   // looks at rsp_full), so psel/penable cannot glitch.
   always_comb begin
      state_d = state_q;
      req_ren = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      rsp_wen = 1'b0;
      busy    = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (!req_empty) state_d = FETCH;
         end
         FETCH: begin
            req_ren = 1'b1;
            state_d = LOAD;
         end
         LOAD: begin
            state_d = SETUP;
         end
         SETUP: begin
            psel    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready || expired) state_d = cmd_wr ? IDLE : RESP;
         end
         RESP: begin
            if (!rsp_full) begin
               rsp_wen = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command registers are only written in LOAD, so the APB address/data
   // stay put from SETUP to the end of ACCESS and do not toggle while idle.
   always_ff @(posedge apb_clk or negedge reset) begin
      if (!reset) begin
         cmd_wr    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (state_q == LOAD) begin
         cmd_wr    <= req_data[WR_BIT];
         cmd_addr  <= req_data[A_MSB:A_LSB];
         cmd_wdata <= req_data[D_MSB:D_LSB];
      end
   end

   // Read data is captured on completion and held after the push. An aborted
   // read returns all ones so the requester side sees a recognisable value.
   always_ff @(posedge apb_clk or negedge reset) begin
      if (!reset) begin
         rsp_data <= '0;
      end else if ((state_q == ACCESS) && !cmd_wr) begin
         if (pready) begin
            rsp_data <= prdata;
         end else if (expired) begin
            rsp_data <= {WIDTH{1'b1}};
         end
      end
   end

   assign pwrite = cmd_wr;
   assign paddr  = cmd_addr;
   assign pwdata = cmd_wdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: self-checking bench for apb_master_ctrl.
// Request FIFO and APB completer are modelled in the bench; every completed
// transfer is compared against the request stream in FIFO order and every
// response push against the read data the completer returned.
module tb_apb_master_ctrl;

   localparam int W  = 32;
   localparam int A  = 16;
   localparam int RW = W + A + 1;

   logic          apb_clk   = 1'b0;
   logic          reset     = 1'b0;
   logic          req_empty = 1'b1;
   logic [RW-1:0] req_data  = '0;
   logic          rsp_full  = 1'b0;
   logic [W-1:0]  prdata    = '0;
   logic          pready    = 1'b0;

   logic          req_ren;
   logic          rsp_wen;
   logic [W-1:0]  rsp_data;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [A-1:0]  paddr;
   logic [W-1:0]  pwdata;
   logic          busy;
   logic          timeout_err;

   apb_master_ctrl #(.WIDTH(W), .ADDRBITS(A), .TIMEOUT(8)) dut (
      .apb_clk     (apb_clk),
      .reset       (reset),
      .req_empty   (req_empty),
      .req_data    (req_data),
      .req_ren     (req_ren),
      .rsp_full    (rsp_full),
      .rsp_wen     (rsp_wen),
      .rsp_data    (rsp_data),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // ---------------- clock / global bound ----------------
   always #5 apb_clk = ~apb_clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- bench state ----------------
   typedef struct {
      logic         wr;
      logic [A-1:0] addr;
      logic [W-1:0] wdata;
      int           waits;
      logic [W-1:0] rdata;
      int           exp_busy;
   } vec_t;

   logic [RW-1:0] req_q[$];       // request FIFO contents
   logic [RW-1:0] exp_xfer_q[$];  // transfers expected on APB, in order
   logic [W-1:0]  exp_q[$];       // responses expected in the response FIFO
   int            waits_q[$];     // forced wait states per transfer
   logic [W-1:0]  rdata_q[$];     // forced read data per transfer

   int           pass_cnt  = 0;
   int           total_cnt = 0;
   int           ren_cnt   = 0;
   int           done_cnt  = 0;
   bit           ren_seen  = 1'b0;
   bit           prev_psel = 1'b0;
   logic [A-1:0] setup_addr = '0;
   int           acc_cnt   = 0;
   int           cur_waits = 0;
   logic [W-1:0] cur_rdata = '0;
   bit           rand_full = 1'b0;
   int           full_hold = 0;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_req(input logic wr, input logic [A-1:0] addr, input logic [W-1:0] wdata);
      req_q.push_back({wr, addr, wdata});
      exp_xfer_q.push_back({wr, addr, wdata});
      req_empty = 1'b0;
   endtask

   // Runs at the falling edge, away from the active edge.
   task automatic monitor();
      logic [RW-1:0] e;
      if (req_ren) ren_cnt++;
      ren_seen = req_ren;
      if (psel && !penable) begin
         check("setup_gap", prev_psel, 1'b0);
         setup_addr = paddr;
      end
      if (psel && penable && pready) begin
         check("xfer_pending", exp_xfer_q.size() != 0, 1'b1);
         if (exp_xfer_q.size() != 0) begin
            e = exp_xfer_q.pop_front();
            check("pwrite", pwrite, e[RW-1]);
            check("paddr", paddr, e[W+A-1:W]);
            check("paddr_stable", paddr, setup_addr);
            if (e[RW-1]) check("pwdata", pwdata, e[W-1:0]);
            else exp_q.push_back(prdata);
         end
         done_cnt++;
      end
      if (rsp_wen) begin
         check("rsp_wen_not_full", rsp_full, 1'b0);
         check("rsp_pending", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check("rsp_data", rsp_data, exp_q.pop_front());
      end
      prev_psel = psel;
   endtask

   // One clock: update FIFO/completer/backpressure after the edge, then monitor.
   task automatic tick();
      @(posedge apb_clk);
      #1;
      if (ren_seen && req_q.size() != 0) req_data = req_q.pop_front();
      req_empty = (req_q.size() == 0);
      if (psel && penable) begin
         if (acc_cnt == 0) begin
            if (waits_q.size() != 0) cur_waits = waits_q.pop_front();
            else cur_waits = int'($urandom_range(0, 3));
            if (rdata_q.size() != 0) cur_rdata = rdata_q.pop_front();
            else cur_rdata = $urandom;
         end
         pready = (acc_cnt >= cur_waits);
         prdata = pready ? cur_rdata : $urandom;
         acc_cnt++;
      end else begin
         // pready/prdata are garbage outside ACCESS and must be ignored.
         acc_cnt = 0;
         pready  = 1'($urandom_range(0, 1));
         prdata  = $urandom;
      end
      if (rand_full) rsp_full = ($urandom_range(0, 2) == 0);
      else rsp_full = (full_hold > 0);
      if (full_hold > 0) full_hold--;
      @(negedge apb_clk);
      monitor();
   endtask

   task automatic drain(input string name, input int max);
      int n;
      n = 0;
      while ((busy || req_q.size() != 0) && n < max) begin
         tick();
         n++;
      end
      check(name, busy, 1'b0);
   endtask

   // ---------------- test ----------------
   initial begin
      vec_t vt[6];
      int   lat, bc, n, rc0, d0, pushes, acc;

      vt[0] = '{1'b1, 16'h0040, 32'hDEADBEEF, 0, 32'h0,        4};
      vt[1] = '{1'b0, 16'h0010, 32'h0,        3, 32'h12345678, 8};
      vt[2] = '{1'b1, 16'hFFFF, 32'h00000001, 2, 32'h0,        6};
      vt[3] = '{1'b0, 16'h0000, 32'h0,        0, 32'hFFFFFFFF, 5};
      vt[4] = '{1'b1, 16'h8001, 32'hA5A5A5A5, 1, 32'h0,        5};
      vt[5] = '{1'b0, 16'h7FFE, 32'h0,        5, 32'h0F0F0F0F, 10};

      // reset state
      repeat (3) @(negedge apb_clk);
      check("rst_psel", psel, 1'b0);
      check("rst_penable", penable, 1'b0);
      check("rst_req_ren", req_ren, 1'b0);
      check("rst_rsp_wen", rsp_wen, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout_err", timeout_err, 1'b0);
      check("rst_pwrite", pwrite, 1'b0);
      check("rst_paddr", paddr, 16'h0);
      check("rst_pwdata", pwdata, 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      reset = 1'b1;
      repeat (2) tick();
      check("idle_busy", busy, 1'b0);

      // table-driven single transfers
      for (int i = 0; i < 6; i++) begin
         waits_q.push_back(vt[i].waits);
         rdata_q.push_back(vt[i].rdata);
         d0 = done_cnt;
         push_req(vt[i].wr, vt[i].addr, vt[i].wdata);
         lat = 0;
         bc  = 0;
         n   = 0;
         do begin
            tick();
            n++;
            if (psel && lat == 0) lat = n;
            if (busy) bc++;
         end while (busy && n < 60);
         check("vec_latency", lat, 3);
         check("vec_busy_cycles", bc, vt[i].exp_busy);
         check("vec_done", done_cnt - d0, 1);
         if (!vt[i].wr) check("vec_rsp_hold", rsp_data, vt[i].rdata);
      end

      // back-to-back writes
      rc0 = ren_cnt;
      d0  = done_cnt;
      for (int i = 0; i < 3; i++) begin
         waits_q.push_back(0);
         rdata_q.push_back(32'h0);
      end
      push_req(1'b1, 16'h0100, 32'h11111111);
      push_req(1'b1, 16'h0200, 32'h22222222);
      push_req(1'b1, 16'h0300, 32'h33333333);
      n = 0;
      while (done_cnt < d0 + 3 && n < 60) begin
         tick();
         n++;
      end
      check("b2b_done", done_cnt - d0, 3);
      drain("b2b_drain", 20);
      check("b2b_ren", ren_cnt - rc0, 3);

      // response backpressure: 6 full cycles after a read completes
      full_hold = 1000;
      d0 = done_cnt;
      waits_q.push_back(0);  rdata_q.push_back(32'hCAFEF00D);
      waits_q.push_back(0);  rdata_q.push_back(32'h0);
      push_req(1'b0, 16'h0010, 32'h0);
      push_req(1'b1, 16'h0020, 32'h55AA55AA);
      n = 0;
      while (done_cnt == d0 && n < 40) begin
         tick();
         n++;
      end
      check("bp_read_done", done_cnt - d0, 1);
      full_hold = 6;
      rc0 = ren_cnt;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("bp_no_push", rsp_wen, 1'b0);
         check("bp_busy", busy, 1'b1);
      end
      tick();
      check("bp_push", rsp_wen, 1'b1);
      check("bp_rsp_data", rsp_data, 32'hCAFEF00D);
      check("bp_no_fetch", ren_cnt - rc0, 0);
      drain("bp_drain", 30);

      // reset in the middle of ACCESS
      waits_q.push_back(100);
      rdata_q.push_back(32'h0);
      push_req(1'b0, 16'h0123, 32'h0);
      n = 0;
      while (!(psel && penable) && n < 20) begin
         tick();
         n++;
      end
      check("mid_in_access", penable, 1'b1);
      repeat (2) tick();
      reset = 1'b0;
      #1;
      check("mid_psel", psel, 1'b0);
      check("mid_penable", penable, 1'b0);
      check("mid_busy", busy, 1'b0);
      check("mid_paddr", paddr, 16'h0);
      exp_xfer_q.delete();
      repeat (3) tick();
      @(negedge apb_clk);
      reset = 1'b1;
      rc0 = ren_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_idle", busy, 1'b0);
      end
      check("post_rst_no_fetch", ren_cnt - rc0, 0);

      // randomized traffic with random backpressure
      rand_full = 1'b1;
      pushes = 0;
      for (int c = 0; c < 800 && pushes < 40; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            push_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)), $urandom);
            pushes++;
         end
         tick();
      end
      drain("rand_drain", 600);
      rand_full = 1'b0;
      tick();
      check("rand_xfers_left", exp_xfer_q.size(), 0);
      check("rand_rsps_left", exp_q.size(), 0);

`ifdef APBM_TIMEOUT_EN
      // read whose completer never answers: aborts after 8 wait cycles
      waits_q.push_back(1000);
      rdata_q.push_back(32'h0);
      push_req(1'b0, 16'h0044, 32'h0);
      void'(exp_xfer_q.pop_back());
      exp_q.push_back(32'hFFFFFFFF);
      n = 0;
      while (!(psel && penable) && n < 20) begin
         tick();
         n++;
      end
      acc = 0;
      n   = 0;
      while (penable && n < 40) begin
         acc++;
         tick();
         n++;
      end
      check("to_access_cycles", acc, 9);
      drain("to_drain", 20);
      check("to_rsp_left", exp_q.size(), 0);
      check("to_err_set", timeout_err, 1'b1);
      waits_q.push_back(0);
      rdata_q.push_back(32'h0);
      push_req(1'b1, 16'h0050, 32'h12121212);
      drain("to_after_drain", 20);
      check("to_err_sticky", timeout_err, 1'b1);
`else
      check("no_timeout_err", timeout_err, 1'b0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
